uart_rx_fifo: RTL

//  Receive-side byte buffer sitting directly downstream of the UART receiver.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_fifo_mem.sv | 31 +++
 rtl/uart_rx_fifo.sv | 109 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART defaults used by the receiver, the transmitter and their byte buffers.
package uart_pkg;

  localparam int UART_DBIT        = 8;
  localparam int UART_FIFO_ADDR_W = 4;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the UART byte buffers.
// Writes are synchronous. Reads are asynchronous, so the head word appears the
// same cycle its address is presented. Contents are never reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DBIT   = UART_DBIT,
  parameter int ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [DBIT-1:0]   wrData_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic [DBIT-1:0]   rdData_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DBIT-1:0] mem_q [DEPTH];

  // Store the incoming word at the write address whenever a write is accepted.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer placed directly after the UART receiver.
// Each word that arrives with the receiver's done strobe is captured into a
// circular buffer and offered to the host on a first-word-fall-through
// valid/ready port. The buffer also reports its fill level, an almost-full flag
// that drives RTS, and a sticky overflow error.
// A write into a full buffer is still accepted when the host pops in the same
// cycle. In that case the freed slot is the same slot being written.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT     = UART_DBIT,
  parameter int ADDR_W   = UART_FIFO_ADDR_W,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_tick,
  input  logic [DBIT-1:0]   wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DBIT-1:0]   rd_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W + 1)'(AF_LEVEL);

  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;

  logic pop;
  logic wrAccept;
  logic wrDrop;

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_CNT);
  assign almost_full = (count_q >= AF_CNT);
  assign rd_valid    = !empty;
  assign count       = count_q;
  assign overflow    = overflow_q;

  assign pop      = rd_valid & rd_ready;
  assign wrAccept = wr_tick & (!full | pop);
  assign wrDrop   = wr_tick & full & !pop;

  uart_fifo_mem #(
    .DBIT   (DBIT),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk      (clk),
    .wrEn_i   (wrAccept),
    .wrAddr_i (wrPtr_q),
    .wrData_i (wr_data),
    .rdAddr_i (rdPtr_q),
    .rdData_o (rd_data)
  );

  // Next-state logic for the pointers, the occupancy count and the sticky overflow flag.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (wrAccept) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end

    case ({wrAccept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (clr_overflow) begin
      overflow_d = 1'b0;
    end
    if (wrDrop) begin
      overflow_d = 1'b1;
    end
  end

  // Registered buffer state. Reset discards every stored word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
